// File: rtl/seq_pkg.sv
// Shared types and defaults for the bit serializer feeding the 1011 sequence detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int   SEQ_WORD_W   = 8;
    localparam logic SEQ_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_piso_shreg.sv
// Loadable parallel-in/serial-out shift register.
// Shift direction: MSB first by default, LSB first when SER_LSB_FIRST_EN is defined.
module seq_piso_shreg
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
`ifdef SER_LSB_FIRST_EN
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`else
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`endif
        end
    end

    // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

`ifdef SER_LSB_FIRST_EN
    assign bit_o = shreg_q[0];
`else
    assign bit_o = shreg_q[WIDTH-1];
`endif

endmodule

// File: rtl/seq_bit_serializer.sv
// Valid/ready parallel-to-serial stage: one bit per clock, no bubble between words.
// Optional build macro SER_LSB_FIRST_EN selects LSB-first bit order (inside seq_piso_shreg).
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH    = SEQ_WORD_W,
    parameter logic IDLE_BIT = SEQ_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;
    logic             accept;
    logic             load;
    logic             shift;
    logic             shreg_bit;

    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign data_ready = (state_q == IDLE) || last_bit;
    assign accept     = data_valid && data_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    shift = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    seq_piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (data_in),
        .bit_o   (shreg_bit)
    );

    // Outputs derive only from flops, so an asynchronous reset clears them at once.
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign ser_bit   = (state_q == SHIFT) ? shreg_bit : IDLE_BIT;
    assign word_done = last_bit;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: word-level model plus directed scenarios.
module tb_seq_bit_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready, ser_bit, ser_valid, busy, word_done;

    int n_checks = 0;
    int n_fail   = 0;

    seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .word_done  (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Word-level model: rem = bits of the current word still to appear on ser_bit.
    int           rem = 0;
    logic [W-1:0] m_word = '0;
    logic         m_ready;
    logic         m_bit;

    assign m_ready = (rem <= 1);
`ifdef SER_LSB_FIRST_EN
    assign m_bit = (rem > 0) ? m_word[W-rem] : IDLE;
`else
    assign m_bit = (rem > 0) ? m_word[rem-1] : IDLE;
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= 0;
        end else if (data_valid && m_ready) begin
            m_word <= data_in;
            rem    <= W;
        end else if (rem > 0) begin
            rem <= rem - 1;
        end
    end

    // Per-cycle comparison against the model, plus a record of the serial stream.
    logic bits_q[$];
    int   vcyc[$];
    int   done_at[$];
    int   cycle = 0;

    always @(negedge clk) begin
        cycle++;
        if (reset) begin
            check("cyc_data_ready", 32'(data_ready), 32'(m_ready));
            check("cyc_ser_valid",  32'(ser_valid),  32'(rem > 0));
            check("cyc_busy",       32'(busy),       32'(rem > 0));
            check("cyc_word_done",  32'(word_done),  32'(rem == 1));
            check("cyc_ser_bit",    32'(ser_bit),    32'(m_bit));
            if (ser_valid) begin
                bits_q.push_back(ser_bit);
                vcyc.push_back(cycle);
            end
            if (word_done) done_at.push_back(bits_q.size());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return #1 after the edge that accepts it.
    task automatic send_word(input logic [W-1:0] d);
        bit taken = 0;
        data_in    = d;
        data_valid = 1'b1;
        for (int i = 0; i < 40 && !taken; i++) begin
            taken = m_ready;
            step();
        end
        data_valid = 1'b0;
        if (!taken) check("send_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pack_bits(input int from, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], bits_q[from+i]};
        return v;
    endfunction

`ifdef SER_LSB_FIRST_EN
    localparam logic [7:0]  EXP_B0   = 8'h0D;
    localparam logic [15:0] EXP_ABCD = 16'hD5B3;
    localparam logic [15:0] EXP_AA0F = 16'h55F0;
    localparam logic [7:0]  EXP_01   = 8'h80;
    localparam logic [3:0]  EXP_HEAD = 4'b0000;
`else
    localparam logic [7:0]  EXP_B0   = 8'hB0;
    localparam logic [15:0] EXP_ABCD = 16'hABCD;
    localparam logic [15:0] EXP_AA0F = 16'hAA0F;
    localparam logic [7:0]  EXP_01   = 8'h01;
    localparam logic [3:0]  EXP_HEAD = 4'b1011;
`endif

    initial begin
        int s, d, v;

        // Reset state
        #12;
        check("rst_data_ready", 32'(data_ready), 32'd1);
        check("rst_ser_valid",  32'(ser_valid),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_word_done",  32'(word_done),  32'd0);
        check("rst_ser_bit",    32'(ser_bit),    32'(IDLE));
        reset = 1'b1;
        step();

        // 1: single word
        s = bits_q.size(); d = done_at.size();
        send_word(8'hB0);
        check("s1_first_valid", 32'(ser_valid), 32'd1);
        repeat (10) step();
        check("s1_nbits",  32'(bits_q.size() - s), 32'd8);
        check("s1_stream", pack_bits(s, 8), 32'(EXP_B0));
        check("s1_head_1011", pack_bits(s, 4), 32'(EXP_HEAD));
        check("s1_done_cnt", 32'(done_at.size() - d), 32'd1);
        if (done_at.size() > d) check("s1_done_pos", 32'(done_at[d] - s), 32'd8);
        check("s1_idle_valid", 32'(ser_valid), 32'd0);
        check("s1_idle_bit",   32'(ser_bit),   32'(IDLE));

        // 2: back-to-back
        s = bits_q.size(); d = done_at.size();
        send_word(8'hAB);
        send_word(8'hCD);
        repeat (12) step();
        check("s2_nbits", 32'(bits_q.size() - s), 32'd16);
        if (bits_q.size() - s >= 16) begin
            check("s2_stream", pack_bits(s, 16), 32'(EXP_ABCD));
            check("s2_contig", 32'(vcyc[s+15] - vcyc[s]), 32'd15);
        end
        check("s2_done_cnt", 32'(done_at.size() - d), 32'd2);
        if (done_at.size() - d >= 2) check("s2_done_gap", 32'(done_at[d+1] - done_at[d]), 32'd8);

        // 3: backpressure during bit 2
        s = bits_q.size();
        send_word(8'hAA);
        step(); step();
        data_in = 8'h0F; data_valid = 1'b1;
        #1;
        check("s3_ready_low", 32'(data_ready), 32'd0);
        send_word(8'h0F);
        repeat (12) step();
        check("s3_nbits", 32'(bits_q.size() - s), 32'd16);
        if (bits_q.size() - s >= 16) begin
            check("s3_stream", pack_bits(s, 16), 32'(EXP_AA0F));
            check("s3_contig", 32'(vcyc[s+15] - vcyc[s]), 32'd15);
        end

        // 4: asynchronous reset during bit 4
        send_word(8'hFF);
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        check("s4_valid_drop", 32'(ser_valid), 32'd0);
        check("s4_busy_drop",  32'(busy),      32'd0);
        check("s4_done_drop",  32'(word_done), 32'd0);
        check("s4_bit_idle",   32'(ser_bit),   32'(IDLE));
        check("s4_ready",      32'(data_ready), 32'd1);
        step(); step();
        #2 reset = 1'b1;
        step();
        s = bits_q.size(); d = done_at.size();
        send_word(8'h01);
        repeat (10) step();
        check("s4_nbits",  32'(bits_q.size() - s), 32'd8);
        check("s4_stream", pack_bits(s, 8), 32'(EXP_01));
        check("s4_done_cnt", 32'(done_at.size() - d), 32'd1);

        // 5: idle fill
        v = bits_q.size();
        for (int i = 0; i < 20; i++) begin
            step();
            check("s5_ready", 32'(data_ready), 32'd1);
            check("s5_bit",   32'(ser_bit),    32'(IDLE));
        end
        check("s5_no_valid", 32'(bits_q.size() - v), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial stage directly upstream of the 1011 sequence detector. Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per clock on ser_bit, which drives the detector's inp_bit. Back-to-back words stream with no bubble. Between words it drives a fixed idle fill bit.

Parameters:
WIDTH, 8, word width in bits (must be >= 2).
IDLE_BIT, 0, value driven on ser_bit when no word is shifting.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
data_in  input  WIDTH  parallel word; sampled on an accept.
data_valid  input  1  upstream offers data_in.
data_ready  output  1  block can accept a word this cycle.
ser_bit  output  1  serial bit to the detector's inp_bit; registered.
ser_valid  output  1  high while ser_bit carries a word bit.
busy  output  1  high in the SHIFT state.
word_done  output  1  one-cycle pulse on the cycle the last bit of a word is on ser_bit.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0, ser_bit=IDLE_BIT, ser_valid=0, busy=0, word_done=0. data_ready is combinational and reads 1 after reset.
- Accept = data_valid & data_ready, sampled on the rising edge.
- data_ready is high when either:
  - state=IDLE, or
  - state=SHIFT and the counter = WIDTH-1 (the last bit is on ser_bit).
- States:
  - IDLE: on accept, load data_in, counter=0, go to SHIFT.
  - SHIFT: each cycle advance one bit and increment the counter.
  - At counter=WIDTH-1 with accept: reload, counter=0, stay in SHIFT. This gives zero gap between words.
  - At counter=WIDTH-1 without accept: go to IDLE.
- Latency: a word accepted at edge N puts its first bit on ser_bit for the cycle after edge N. Bit k appears k cycles later. ser_valid is high for exactly WIDTH cycles per word.
- Bit order: MSB first (data_in[WIDTH-1] first).
- ser_bit=IDLE_BIT and ser_valid=0 whenever state=IDLE.
- word_done = (state=SHIFT) & (counter=WIDTH-1).
- data_in changing while not accepted has no effect. data_valid held high while busy is not consumed until data_ready=1.
- Counter width is clog2(WIDTH); the counter never exceeds WIDTH-1.
- Reset mid-word: the word is aborted immediately, with no partial completion and no word_done. The first cycle after release behaves as IDLE.

Optional Feature:
Macro: SER_LSB_FIRST_EN.
- Defined: bits shift out LSB first (data_in[0] first).
- Undefined: MSB first.
- Handshake, latency, word_done timing and idle behaviour are identical in both builds.

Decomposition:
- Shared package seq_pkg holds:
  - the state encoding ser_state_t: IDLE=0, SHIFT=1;
  - the default word width constant SEQ_WORD_W=8;
  - the idle fill bit constant SEQ_IDLE_BIT=0.
- One natural sub-module: seq_piso_shreg, the loadable shift register. It has inputs load, shift and data, and outputs the current serial bit; the SER_LSB_FIRST_EN direction choice lives inside it. The FSM, counter and handshake stay in the top.

Test Plan:
1. Single word: after reset release, send data_in=8'hB0 with data_valid for one cycle.
   - ser_bit over 8 cycles = 1,0,1,1,0,0,0,0 with ser_valid=1.
   - word_done on the 8th cycle, then ser_bit=0 and ser_valid=0.
   - Downstream detector seq_seen pulses after the 4th bit.
2. Back-to-back: hold data_valid with 8'hAB then 8'hCD.
   - 16 contiguous ser_valid cycles with bits 1010101111001101.
   - data_ready high only in the cycles where counter=7 or state=IDLE; two word_done pulses 8 cycles apart.
3. Backpressure: raise data_valid with 8'h0F during bit 2 of a shifting word.
   - data_ready stays 0 until the last bit; 8'h0F starts the cycle immediately after, with no gap.
4. Reset mid-word: assert reset=0 asynchronously during bit 4 of 8'hFF.
   - ser_valid, busy and word_done drop at once without waiting for a clock; ser_bit=IDLE_BIT.
   - After release, 8'h01 serializes cleanly.
5. Idle fill: no data_valid for 20 cycles.
   - ser_bit=IDLE_BIT, ser_valid=0 and data_ready=1 throughout.
6. SER_LSB_FIRST_EN build: send 8'hB0.
   - ser_bit sequence = 0,0,0,0,1,1,0,1; handshake timing matches scenario 1.
